// File: rtl/ccff_stream_loader.sv
// Configuration-chain loader: takes bitstream words over valid/ready and shifts them
// MSB-first onto ccff_head with a per-cycle prog_clk enable, then runs a loopback check.
module ccff_stream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 4096,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              prog_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              check_err,
    output logic [CNT_W-1:0]  bit_count
);
    localparam int SC_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SC_W-1:0]  SC_FULL   = SC_W'(WORD_W);
    localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);
    localparam logic [SC_W-1:0]  SC_ZERO   = {SC_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [WORD_W-1:0] hold_r;
    logic              hold_valid_r;
    logic [WORD_W-1:0] shift_r;
    logic [SC_W-1:0]   shift_cnt_r;
    logic              head_r;
    logic              first_bit_r;
    logic              check_cyc_r;
    logic              busy_r;
    logic              done_r;
    logic              check_err_r;
    logic [CNT_W-1:0]  bit_count_r;

    logic shift_en_s;
    logic accept_s;
    logic refill_s;
    logic last_shift_s;

    // Per-cycle shift, handshake and refill decode; abort kills the shift in the same cycle.
    always_comb begin
        shift_en_s   = 1'b0;
        accept_s     = 1'b0;
        refill_s     = 1'b0;
        last_shift_s = 1'b0;
        if ((state_r == LOAD) && !abort) begin
            shift_en_s   = (shift_cnt_r != SC_ZERO) && (bit_count_r < CHAIN_END);
            accept_s     = word_valid && !hold_valid_r;
            refill_s     = hold_valid_r &&
                           ((shift_cnt_r == SC_ZERO) || (shift_en_s && (shift_cnt_r == SC_ONE)));
            last_shift_s = shift_en_s && (bit_count_r == LAST_BIT);
        end else begin
            shift_en_s   = 1'b0;
            accept_s     = 1'b0;
            refill_s     = 1'b0;
            last_shift_s = 1'b0;
        end
    end

    // Sequencer, two-stage word buffer, bit counter and loopback comparison.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_r      <= IDLE;
            hold_r       <= {WORD_W{1'b0}};
            hold_valid_r <= 1'b0;
            shift_r      <= {WORD_W{1'b0}};
            shift_cnt_r  <= SC_ZERO;
            head_r       <= 1'b0;
            first_bit_r  <= 1'b0;
            check_cyc_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            check_err_r  <= 1'b0;
            bit_count_r  <= CNT_ZERO;
        end else if (abort) begin
            state_r      <= IDLE;
            hold_valid_r <= 1'b0;
            shift_cnt_r  <= SC_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r      <= LOAD;
                        busy_r       <= 1'b1;
                        bit_count_r  <= CNT_ZERO;
                        check_err_r  <= 1'b0;
                        hold_valid_r <= 1'b0;
                        shift_cnt_r  <= SC_ZERO;
                    end
                end
                LOAD: begin
                    if (shift_en_s) begin
                        bit_count_r <= bit_count_r + CNT_ONE;
                        head_r      <= shift_r[WORD_W-1];
                        if (bit_count_r == CNT_ZERO) begin
                            first_bit_r <= shift_r[WORD_W-1];
                        end
                    end
                    // Refill wins over the shift when the last bit is consumed: no bubble.
                    if (refill_s) begin
                        shift_r     <= hold_r;
                        shift_cnt_r <= SC_FULL;
                    end else if (shift_en_s) begin
                        shift_r     <= {shift_r[WORD_W-2:0], 1'b0};
                        shift_cnt_r <= shift_cnt_r - SC_ONE;
                    end
                    if (accept_s) begin
                        hold_r       <= word_data;
                        hold_valid_r <= 1'b1;
                    end else if (refill_s) begin
                        hold_valid_r <= 1'b0;
                    end
                    if (last_shift_s) begin
                        state_r      <= CHECK;
                        check_cyc_r  <= 1'b0;
                        hold_valid_r <= 1'b0;
                        shift_cnt_r  <= SC_ZERO;
                    end
                end
                CHECK: begin
                    if (ccff_tail != first_bit_r) begin
                        check_err_r <= 1'b1;
                    end
                    check_cyc_r <= 1'b1;
                    if (check_cyc_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign word_ready  = (state_r == LOAD) && !hold_valid_r;
    assign prog_clk_en = shift_en_s;
    assign ccff_head   = shift_en_s ? shift_r[WORD_W-1] : head_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign check_err   = check_err_r;
    assign bit_count   = bit_count_r;

endmodule
